// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational ICache and
// presents one registered word per cycle to decode over a valid/ready handshake.
module fetch_controller #(
    parameter int          WIDTH     = 32,
    parameter int          WIDTH_ADD = 32,
    parameter int          SIZE      = 108,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WIDTH_ADD-1:0] icache_addr,
    input  logic [WIDTH-1:0]     icache_data,
    output logic [WIDTH-1:0]     instr_out,
    output logic [WIDTH_ADD-1:0] pc_out,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WIDTH_ADD-1:0] redirect_addr,
    output logic                 halted,
    output logic                 fault,
    output logic [15:0]          fetch_count
);

    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    state_t               state_q, state_d;
    logic [WIDTH_ADD-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]     instr_q, instr_d;
    logic [WIDTH_ADD-1:0] pc_out_q, pc_out_d;
    logic                 valid_q, valid_d;
    logic                 halted_q, halted_d;
    logic                 fault_q, fault_d;
    logic [15:0]          count_q, count_d;

    logic                 accept, slot_free, pc_legal;
    logic [WIDTH_ADD:0]   pc_last;

    // Last byte of the word, one bit wider so the bound check cannot wrap.
    assign pc_last   = {1'b0, pc_q} + (WIDTH_ADD+1)'(3);
    assign pc_legal  = (pc_q[1:0] == 2'b00) && (pc_last <= (WIDTH_ADD+1)'(SIZE-1));
    assign accept    = valid_q && instr_ready;
    assign slot_free = !valid_q || instr_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        count_d  = accept ? count_q + 16'd1 : count_q;

        case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d    = redirect_addr;
                    valid_d = 1'b0;
                end else if (!pc_legal) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    if (slot_free) valid_d = 1'b0;
                end else if (slot_free) begin
                    if (stall) begin
                        valid_d = 1'b0;
                    end else if (icache_data == HALT_WORD) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                        valid_d  = 1'b0;
                    end else begin
                        instr_d  = icache_data;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + WIDTH_ADD'(4);
                    end
                end
            end
            // Terminal states only drain a word that was already presented.
            default: begin
                if (accept) valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= '0;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
        end
    end

    assign icache_addr = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a 108-byte ICache image model feeds the
// DUT and every accepted word is compared against the expected {pc, word} queue.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] icache_addr, icache_data, instr_out, pc_out, redirect_addr;
    logic        instr_valid, instr_ready, stall, redirect, halted, fault;
    logic [15:0] fetch_count;

    logic [31:0] mem [0:26];
    logic [63:0] sb [$];
    int          n_chk = 0;
    int          n_pass = 0;

    fetch_controller dut (
        .clk(clk), .rst(rst), .icache_addr(icache_addr), .icache_data(icache_data),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign icache_data = (icache_addr < 32'd108 && icache_addr[1:0] == 2'b00)
                         ? mem[icache_addr >> 2] : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int start, input int n);
        for (int i = 0; i < n; i++)
            sb.push_back({32'(start + 4*i), mem[(start + 4*i) / 4]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        stall = 1'b0;
        step();
        step();
        sb.delete();
        chk("rst_addr",  icache_addr, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_pc",    pc_out, 0);
        chk("rst_flags", {instr_valid, halted, fault}, 0);
        chk("rst_count", fetch_count, 0);
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 100 && !halted; i++) step();
        chk("halt_timeout", halted, 1);
    endtask

    // Each handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) chk("sb_underflow", {pc_out, instr_out}, 0);
            else chk("sb_word", {pc_out, instr_out}, sb.pop_front());
        end
    end

    initial begin
        mem[0] = 32'hE0210004;
        mem[1] = 32'hE0420005;
        for (int i = 2; i < 26; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[26] = 32'hFFFFFFFF;
        instr_ready = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_addr = '0;

        // Full image run to the sentinel.
        do_reset();
        push_seq(0, 26);
        rst = 1'b0;
        chk("first_idle", instr_valid, 0);
        step();
        chk("c2_instr", {instr_valid, instr_out, pc_out}, {1'b1, 32'hE0210004, 32'd0});
        step();
        chk("c3_instr", {instr_valid, instr_out, pc_out}, {1'b1, 32'hE0420005, 32'd4});
        wait_halt();
        step();
        chk("halt_valid", instr_valid, 0);
        chk("halt_count", fetch_count, 26);
        chk("halt_addr",  icache_addr, 104);
        chk("halt_sb_empty", sb.size(), 0);

        // Backpressure on @8, then redirect while @16 is held.
        do_reset();
        push_seq(0, 5);
        rst = 1'b0;
        step();
        step();
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", {instr_valid, instr_out, pc_out}, {1'b1, mem[2], 32'd8});
            chk("bp_pc",    icache_addr, 12);
            chk("bp_count", fetch_count, 2);
        end
        instr_ready = 1'b1;
        step();
        chk("bp_release", {instr_valid, pc_out}, {1'b1, 32'd12});
        chk("bp_count2", fetch_count, 3);
        step();
        chk("at16", {instr_valid, pc_out}, {1'b1, 32'd16});
        instr_ready = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h40;
        step();
        redirect = 1'b0;
        instr_ready = 1'b1;
        sb.delete();
        push_seq(32'h40, 10);
        chk("rd_flush", instr_valid, 0);
        chk("rd_count", fetch_count, 4);
        step();
        chk("rd_target", {instr_valid, pc_out, instr_out}, {1'b1, 32'h40, mem[16]});
        wait_halt();
        chk("rd_final_count", fetch_count, 14);
        chk("rd_sb_empty", sb.size(), 0);

        // Misaligned redirect, then ignored redirect while faulted.
        do_reset();
        rst = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h6A;
        step();
        redirect = 1'b0;
        chk("f_pre", {fault, instr_valid}, 0);
        step();
        chk("f_mis", {fault, instr_valid}, {1'b1, 1'b0});
        redirect = 1'b1;
        redirect_addr = 32'h0;
        step();
        redirect = 1'b0;
        step();
        chk("f_sticky", {fault, instr_valid, icache_addr}, {1'b1, 1'b0, 32'h6A});

        // Out-of-range redirect to 108.
        do_reset();
        rst = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'd108;
        step();
        redirect = 1'b0;
        step();
        chk("f_range", {fault, halted, instr_valid}, {1'b1, 1'b0, 1'b0});

        // Stall mid-run, then reset mid-run.
        do_reset();
        push_seq(0, 3);
        rst = 1'b0;
        step();
        stall = 1'b1;
        step();
        chk("st_1", {instr_valid, icache_addr}, {1'b0, 32'd4});
        step();
        chk("st_2", {instr_valid, icache_addr}, {1'b0, 32'd4});
        stall = 1'b0;
        step();
        chk("st_resume", {instr_valid, pc_out, fetch_count}, {1'b1, 32'd4, 16'd1});
        rst = 1'b1;
        step();
        chk("mid_rst", {icache_addr, instr_out, pc_out, instr_valid, halted, fault, fetch_count}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
